hazard_controller: RTL

- Central hazard and sequencing controller for the 5-stage RV32 pipeline.
- Drives stall/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and drives EX-stage forwarding selects.
- Holds a small FSM for variable-latency data memory (req/ack handshake) with a timeout watchdog.
- Resolves event priority so that the pipeline registers' stall-over-flush precedence never keeps a wrong-path instruction.

---
 rtl/hazard_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: hazard and sequencing controller for the 5-stage RV32 pipeline.
//
// Produces stall/flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers, EX-stage forwarding selects, and tracks variable-latency data
// memory accesses with a sticky timeout watchdog. Stall/flush/forward outputs
// are combinational from the inputs and are forced low while reset is held.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_rs1D, i_rs2D              ID source registers
//   i_rs1E, i_rs2E, i_rdE       EX source/destination registers
//   i_loadE, i_pcsrcE           EX is a load / EX resolved a taken branch
//   i_rdM, i_regwriteM          MEM destination and write enable
//   i_rdW, i_regwriteW          WB destination and write enable
//   i_memreqM, i_memackM        data memory request / completion
//   o_stallF..o_stallM          hold PC and pipeline registers
//   o_flushD, o_flushE, o_flushW insert bubbles
//   o_fwdAE, o_fwdBE            00 regfile, 01 WB result, 10 MEM ALU result
//   o_mem_timeout               sticky watchdog error (cleared only by reset)
//   o_stall_cnt, o_flush_cnt    performance counters
//
// Optional feature: define HAZARD_PERF_EN to build the performance counters;
// otherwise both counter ports are tied to zero.
module hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_rs1D,
  input  logic [4:0]       i_rs2D,
  input  logic [4:0]       i_rs1E,
  input  logic [4:0]       i_rs2E,
  input  logic [4:0]       i_rdE,
  input  logic             i_loadE,
  input  logic             i_pcsrcE,
  input  logic [4:0]       i_rdM,
  input  logic             i_regwriteM,
  input  logic [4:0]       i_rdW,
  input  logic             i_regwriteW,
  input  logic             i_memreqM,
  input  logic             i_memackM,
  output logic             o_stallF,
  output logic             o_stallD,
  output logic             o_stallE,
  output logic             o_stallM,
  output logic             o_flushD,
  output logic             o_flushE,
  output logic             o_flushW,
  output logic [1:0]       o_fwdAE,
  output logic [1:0]       o_fwdBE,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              lw_hz;
  logic              mem_hz;

  // Hazard detection
  assign lw_hz  = i_loadE && (i_rdE != 5'd0) && ((i_rdE == i_rs1D) || (i_rdE == i_rs2D));
  assign mem_hz = i_memreqM && !i_memackM;

  // Saturating increment of the wait counter
  assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);

  // Memory wait FSM and sticky watchdog
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_hz) state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A dropped request is a protocol violation; leave quietly.
          if (i_memackM || !i_memreqM) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_inc;
          end
          if (wait_inc == WAIT_MAX) o_mem_timeout <= 1'b1;
        end
      endcase
    end
  end

  // Stall/flush priority: memory wait > taken branch > load-use
  always_comb begin
    o_stallF = 1'b0;
    o_stallD = 1'b0;
    o_stallE = 1'b0;
    o_stallM = 1'b0;
    o_flushD = 1'b0;
    o_flushE = 1'b0;
    o_flushW = 1'b0;
    if (i_rst_n) begin
      if (mem_hz) begin
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_stallE = 1'b1;
        o_stallM = 1'b1;
        o_flushW = 1'b1;
      end else if (i_pcsrcE) begin
        // IF/ID favours stall over flush, so the load-use stall must not
        // be raised alongside a redirect or the wrong-path op would stay.
        o_flushD = 1'b1;
        o_flushE = 1'b1;
      end else if (lw_hz) begin
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_flushE = 1'b1;
      end
    end
  end

  // Forwarding selects, MEM has priority over WB
  always_comb begin
    o_fwdAE = 2'b00;
    o_fwdBE = 2'b00;
    if (i_rst_n) begin
      if (i_regwriteM && (i_rdM != 5'd0) && (i_rdM == i_rs1E))      o_fwdAE = 2'b10;
      else if (i_regwriteW && (i_rdW != 5'd0) && (i_rdW == i_rs1E)) o_fwdAE = 2'b01;
      if (i_regwriteM && (i_rdM != 5'd0) && (i_rdM == i_rs2E))      o_fwdBE = 2'b10;
      else if (i_regwriteW && (i_rdW != 5'd0) && (i_rdW == i_rs2E)) o_fwdBE = 2'b01;
    end
  end

`ifdef HAZARD_PERF_EN
  // Performance counters, wrapping modulo 2^CNT_W
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_stallF) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      if (o_flushD || o_flushE || o_flushW) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
    end
  end
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule
